// File: rtl/if_fetch_unit_pkg.sv
// if_fetch_unit_pkg: shared constants, fetch FSM encoding and PC helpers.
package if_fetch_unit_pkg;
    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC  = 32'h0000_0000;
    localparam logic [XLEN-1:0] DEFAULT_NOP_INSTR = 32'h0000_0013;
    typedef enum logic [1:0] {BOOT, REQ, WAIT, HOLD} fetch_state_e;
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] a);
        return a & ~32'h3;
    endfunction
endpackage

// File: rtl/if_fetch_unit_if.sv
// if_fetch_unit_if: instruction-memory request/response channel.
interface if_fetch_unit_if;
    import if_fetch_unit_pkg::*;
    logic            req;
    logic [XLEN-1:0] addr;
    logic            ready;
    logic            rvalid;
    logic [XLEN-1:0] rdata;
    modport master (output req, addr, input ready, rvalid, rdata);
    modport slave  (input req, addr, output ready, rvalid, rdata);
endinterface

// File: rtl/if_fetch_unit_pc_reg.sv
// if_pc_reg: program counter with hold / sequential / redirect next-pc select.
module if_pc_reg import if_fetch_unit_pkg::*; #(
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] target_i,
    input  logic            advance_i,
    output logic [XLEN-1:0] pc_o
);
    logic [XLEN-1:0] pc_q, pc_d;
    always_comb pc_d = redirect_i ? align_pc(target_i) : advance_i ? pc_q + 32'd4 : pc_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pc_q <= RESET_PC;
        else        pc_q <= pc_d;
    end
    assign pc_o = pc_q;
endmodule

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction-fetch stage with one outstanding fetch, skid buffer and IF/ID register.
module if_fetch_unit import if_fetch_unit_pkg::*; #(
    parameter logic [XLEN-1:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter logic [XLEN-1:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            is_branch_i,
    input  logic [XLEN-1:0] branch_target_i,
    input  logic            stall_i,
    if_fetch_unit_if.master imem,
    output logic            if_id_valid_o,
    output logic [XLEN-1:0] if_id_pc_o,
    output logic [XLEN-1:0] if_id_instr_o,
    output logic            flush_id_o
);
    fetch_state_e    state_q, state_d;
    logic            kill_q, kill_d;
    logic [XLEN-1:0] skid_q, skid_d;
    logic            valid_q, valid_d;
    logic [XLEN-1:0] ifpc_q, ifpc_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic            flush_q;
    logic            redirect, load;
    logic [XLEN-1:0] load_instr, pc;

    if_pc_reg #(.RESET_PC(RESET_PC)) u_pc (
        .clk(clk), .rst_n(rst_n), .redirect_i(redirect), .target_i(branch_target_i),
        .advance_i(load), .pc_o(pc)
    );

    assign redirect  = is_branch_i && state_q != BOOT;
    assign imem.req  = state_q == REQ;
    assign imem.addr = pc;

    // A redirect kills the in-flight fetch: either via kill_q later, or immediately if data lands now.
    always_comb begin
        state_d    = state_q;
        kill_d     = kill_q;
        skid_d     = skid_q;
        load       = 1'b0;
        load_instr = imem.rdata;
        case (state_q)
            BOOT: state_d = REQ;
            REQ: if (imem.ready) begin
                state_d = WAIT;
                kill_d  = redirect;
            end
            WAIT: if (imem.rvalid) begin
                kill_d = 1'b0;
                if (kill_q || redirect) state_d = REQ;
                else if (!stall_i) begin
                    load    = 1'b1;
                    state_d = REQ;
                end else begin
                    skid_d  = imem.rdata;
                    state_d = HOLD;
                end
            end else if (redirect) kill_d = 1'b1;
            HOLD: if (redirect) state_d = REQ;
            else if (!stall_i) begin
                load       = 1'b1;
                load_instr = skid_q;
                state_d    = REQ;
            end
            default: state_d = BOOT;
        endcase
    end

    always_comb begin
        valid_d = valid_q;
        ifpc_d  = ifpc_q;
        instr_d = instr_q;
        if (redirect) begin
            valid_d = 1'b0;
            instr_d = NOP_INSTR;
        end else if (load) begin
            valid_d = 1'b1;
            ifpc_d  = pc;
            instr_d = load_instr;
        end else if (!stall_i) begin
            valid_d = 1'b0;
            instr_d = NOP_INSTR;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BOOT;
            kill_q  <= 1'b0;
            skid_q  <= '0;
            valid_q <= 1'b0;
            ifpc_q  <= '0;
            instr_q <= NOP_INSTR;
            flush_q <= 1'b0;
        end else begin
            state_q <= state_d;
            kill_q  <= kill_d;
            skid_q  <= skid_d;
            valid_q <= valid_d;
            ifpc_q  <= ifpc_d;
            instr_q <= instr_d;
            flush_q <= redirect;
        end
    end

    assign if_id_valid_o = valid_q;
    assign if_id_pc_o    = ifpc_q;
    assign if_id_instr_o = instr_q;
    assign flush_id_o    = flush_q;
endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: directed and randomized checks of the fetch stage against an epoch-based model.
module tb_if_fetch_unit;
    import if_fetch_unit_pkg::*;
    logic        clk = 1'b0, rst_n = 1'b1;
    logic        is_branch = 1'b0, stall = 1'b0;
    logic [31:0] branch_target = '0;
    logic        if_id_valid, flush_id;
    logic [31:0] if_id_pc, if_id_instr;
    int          n_chk = 0, n_fail = 0;

    if_fetch_unit_if imem ();

    if_fetch_unit dut (
        .clk(clk), .rst_n(rst_n), .is_branch_i(is_branch), .branch_target_i(branch_target),
        .stall_i(stall), .imem(imem), .if_id_valid_o(if_id_valid), .if_id_pc_o(if_id_pc),
        .if_id_instr_o(if_id_instr), .flush_id_o(flush_id)
    );

    always #5 clk = ~clk;

    // Model: every redirect opens a new epoch; a response is kept only if its fetch
    // was issued in the current epoch and no redirect lands in the same cycle.
    logic [31:0] m_pc, m_out_addr, m_held_pc, m_held_instr, e_pc, e_instr;
    logic        m_boot, m_out, m_held, e_valid, e_flush, e_req;
    int unsigned epoch = 0, out_epoch = 0;
    logic        mem_busy = 1'b0;
    logic [31:0] mem_addr = '0;
    int          mem_cnt = 0, lat_min = 1, lat_max = 1;
    logic        s_redir, s_acc, s_ld;
    logic [31:0] s_lpc, s_lins;

    assign e_req = !m_boot && !m_out && !m_held;

    task automatic model_reset();
        m_pc = DEFAULT_RESET_PC; m_boot = 1'b1; m_out = 1'b0; m_held = 1'b0;
        e_valid = 1'b0; e_pc = '0; e_instr = DEFAULT_NOP_INSTR; e_flush = 1'b0;
    endtask

    always @(posedge clk) if (rst_n) begin
        s_redir = is_branch && !m_boot;
        s_acc   = e_req && imem.ready;
        s_ld = 1'b0; s_lpc = '0; s_lins = '0;
        if (m_out && imem.rvalid) begin
            m_out = 1'b0;
            if (out_epoch == epoch && !s_redir) begin
                if (!stall) begin
                    s_ld = 1'b1; s_lpc = m_out_addr; s_lins = imem.rdata;
                end else begin
                    m_held = 1'b1; m_held_pc = m_out_addr; m_held_instr = imem.rdata;
                end
            end
        end else if (m_held && !stall && !s_redir) begin
            s_ld = 1'b1; s_lpc = m_held_pc; s_lins = m_held_instr; m_held = 1'b0;
        end
        if (s_ld) m_pc = s_lpc + 32'd4;
        if (s_acc) begin
            m_out = 1'b1; m_out_addr = m_pc; out_epoch = epoch;
            mem_busy = 1'b1; mem_addr = m_pc; mem_cnt = $urandom_range(lat_max, lat_min) - 1;
        end
        if (s_redir) begin
            m_held = 1'b0; epoch++; m_pc = branch_target & 32'hFFFF_FFFC;
        end
        if (s_redir) begin
            e_valid = 1'b0; e_instr = DEFAULT_NOP_INSTR;
        end else if (s_ld) begin
            e_valid = 1'b1; e_pc = s_lpc; e_instr = s_lins;
        end else if (!stall) begin
            e_valid = 1'b0; e_instr = DEFAULT_NOP_INSTR;
        end
        e_flush = s_redir;
        m_boot  = 1'b0;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("req", 32'(imem.req), 32'(e_req));
        if (e_req) chk("addr", imem.addr, m_pc);
        chk("valid", 32'(if_id_valid), 32'(e_valid));
        chk("if_pc", if_id_pc, e_pc);
        chk("instr", if_id_instr, e_instr);
        chk("flush", 32'(flush_id), 32'(e_flush));
    end

    // Drives one cycle of inputs at negedge+1, then returns one clock later.
    task automatic cyc(input logic r, input logic b, input logic [31:0] t, input logic s, input logic rd);
        imem.rvalid = 1'b0;
        imem.rdata  = $urandom;
        if (mem_busy) begin
            if (mem_cnt == 0) begin
                imem.rvalid = 1'b1; imem.rdata = mem_addr ^ 32'hA5; mem_busy = 1'b0;
            end else mem_cnt--;
        end
        rst_n = r;
        if (!r) model_reset();
        is_branch = b; branch_target = t; stall = s; imem.ready = rd;
        @(negedge clk); #1;
    endtask

    task automatic wait_valid(input logic [31:0] xpc, input logic [31:0] xins, input int xcyc);
        int n = 0;
        do begin
            cyc(1'b1, 1'b0, '0, 1'b0, 1'b1);
            n++;
        end while (!if_id_valid && n < 20);
        chk("lit_valid", 32'(if_id_valid), 32'd1);
        chk("lit_pc", if_id_pc, xpc);
        chk("lit_instr", if_id_instr, xins);
        chk("lit_model_pc", e_pc, xpc);
        chk("lit_lat", 32'(n), 32'(xcyc));
    endtask

    initial begin
        imem.ready = 1'b0; imem.rvalid = 1'b0; imem.rdata = '0;
        model_reset();
        #1;
        cyc(1'b0, 1'b0, '0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, '0, 1'b0, 1'b1);
        chk("rst_valid", 32'(if_id_valid), 32'd0);
        chk("rst_instr", if_id_instr, 32'h13);
        chk("rst_pc", if_id_pc, 32'h0);
        chk("rst_req", 32'(imem.req), 32'd0);
        chk("rst_flush", 32'(flush_id), 32'd0);
        wait_valid(32'h0, 32'hA5, 3);
        wait_valid(32'h4, 32'hA1, 2);
        repeat (3) begin
            cyc(1'b1, 1'b0, '0, 1'b1, 1'b1);
            chk("stall_pc", if_id_pc, 32'h4);
            chk("stall_valid", 32'(if_id_valid), 32'd1);
        end
        chk("hold_req", 32'(imem.req), 32'd0);
        cyc(1'b1, 1'b0, '0, 1'b0, 1'b1);
        chk("skid_pc", if_id_pc, 32'h8);
        chk("skid_instr", if_id_instr, 32'hAD);
        chk("skid_next_addr", imem.addr, 32'hC);
        lat_min = 2; lat_max = 2;
        cyc(1'b1, 1'b0, '0, 1'b0, 1'b1);
        cyc(1'b1, 1'b1, 32'h100, 1'b0, 1'b1);
        chk("br_flush", 32'(flush_id), 32'd1);
        chk("br_req", 32'(imem.req), 32'd0);
        cyc(1'b1, 1'b0, '0, 1'b0, 1'b1);
        chk("br_drop_valid", 32'(if_id_valid), 32'd0);
        chk("br_flush_end", 32'(flush_id), 32'd0);
        chk("br_addr", imem.addr, 32'h100);
        lat_min = 1; lat_max = 1;
        wait_valid(32'h100, 32'h1A5, 2);
        cyc(1'b1, 1'b0, '0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, '0, 1'b0, 1'b0);
        chk("nrdy_addr", imem.addr, 32'h104);
        cyc(1'b1, 1'b1, 32'h203, 1'b0, 1'b0);
        chk("nrdy_redir_addr", imem.addr, 32'h200);
        chk("nrdy_flush", 32'(flush_id), 32'd1);
        cyc(1'b1, 1'b0, '0, 1'b0, 1'b0);
        wait_valid(32'h200, 32'h2A5, 2);
        cyc(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0);
        wait_valid(32'hFFFF_FFFC, 32'hFFFF_FF59, 2);
        chk("wrap_req", 32'(imem.req), 32'd1);
        chk("wrap_addr", imem.addr, 32'h0);
        wait_valid(32'h0, 32'hA5, 2);
        lat_min = 2; lat_max = 2;
        cyc(1'b1, 1'b0, '0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, '0, 1'b0, 1'b1);
        chk("mrst_valid", 32'(if_id_valid), 32'd0);
        chk("mrst_req", 32'(imem.req), 32'd0);
        cyc(1'b1, 1'b0, '0, 1'b0, 1'b1);
        chk("mrst_stale_valid", 32'(if_id_valid), 32'd0);
        chk("mrst_addr", imem.addr, 32'h0);
        lat_min = 1; lat_max = 1;
        wait_valid(32'h0, 32'hA5, 2);
        lat_min = 1; lat_max = 4;
        repeat (4000) begin
            logic [31:0] t;
            t = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
            cyc($urandom_range(0, 199) != 0, $urandom_range(0, 9) == 0, t,
                $urandom_range(0, 3) == 0, $urandom_range(0, 9) < 7);
        end
        cyc(1'b1, 1'b0, '0, 1'b0, 1'b1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
